branch_target_buffer: RTL
=========================

# branch_target_buffer

Direct-mapped branch target buffer that answers fetch-stage lookups for the pipelined MIPS core and learns from resolved branches in the memory stage. Each lookup takes the fetch PC and returns a registered, decode-aligned hit flag, predicted target and taken prediction. The returned target lets the datapath redirect fetch without waiting for the decode-stage branch adder. The memory stage writes actual outcomes back into the buffer, alongside the existing local/global/choose direction predictors.

## Interface
- IDX_W, 4: index width; DEPTH = 2^IDX_W entries
- TAG_W, 30-IDX_W: tag width (derived; not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge)
- pcF  in  32  fetch PC (lookup address)
- stallD  in  1  hold decode-stage lookup result
- flushD  in  1  clear decode-stage lookup result
- branchM  in  1  memory-stage instruction is a conditional branch (update strobe)
- pcM  in  32  PC of the memory-stage branch
- actual_takeM  in  1  resolved outcome of the memory-stage branch
- targetM  in  32  resolved branch target (pc+4+signimm<<2)
- hitD  out  1  valid entry with matching tag for the decode-stage instruction
- pred_takeD  out  1  hitD & ctrD[1]
- targetD  out  32  stored target (0 when hitD==0)
- ctrD  out  2  stored 2-bit saturating counter (0 when hitD==0)

## Operation
- Address split: index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]. pc[1:0] is ignored.
- Each entry holds valid (1 bit), tag (TAG_W bits), target (32 bits) and ctr (2 bits).
- Lookup:
  - The entry at index(pcF) is compared on the clock edge.
  - On a valid, tag-matching entry: hitD=1, targetD=entry.target, ctrD=entry.ctr.
  - On a miss: hitD=0, targetD=0, ctrD=0.
- Decode-stage register priority, highest first:
  - rst==0 clears all outputs.
  - flushD==1 clears all outputs.
  - stallD==1 holds all outputs.
  - Otherwise the outputs load the new lookup.
- Update happens on an edge with branchM==1; nothing changes when branchM==0.
  - Hit, taken: ctr increments, saturating at 11; target is overwritten with targetM.
  - Hit, not taken: ctr decrements, saturating at 00. The entry stays valid.
  - Miss (invalid entry or tag mismatch), taken: allocate the entry. valid=1, tag=tag(pcM), target=targetM, ctr=10 (weakly taken). Any previous occupant is evicted.
  - Miss, not taken: no write.
- Reset: all valid bits are cleared on the reset edge. A branchM update in the same cycle is discarded. Tag, target and ctr contents are don't-care once valid==0.

## Timing
- Lookup latency is one cycle. pcF sampled at edge N appears on hitD/targetD/ctrD/pred_takeD after edge N, aligned with instrD.
- pred_takeD is combinational from the registered hitD/ctrD. It has no extra latency.
- An update written at edge N is visible to lookups sampled at edge N+1 or later.
- Simultaneous lookup and update to the same index at edge N: the lookup returns the pre-update contents (read-old).
- flushD and stallD both high: flush wins and the outputs become 0.
- Reset values: hitD=0, pred_takeD=0, targetD=32'h0, ctrD=2'b00, all valid=0.
- The table is synthesised as registers; there is no multi-cycle access and no backpressure.

## Test plan
All scenarios use IDX_W=4.

- **Cold miss then allocate.** After reset, lookup pcF=0x00400020 gives hitD=0 and targetD=0. Then update branchM=1, pcM=0x00400020, actual_takeM=1, targetM=0x00400100. The next lookup of 0x00400020 gives hitD=1, pred_takeD=1, targetD=0x00400100, ctrD=10.
- **Counter saturation.** On that entry, apply two not-taken updates: ctrD goes 01 then 00, with hitD=1 and pred_takeD=0. Then apply four taken updates: ctrD goes 01, 10, 11, 11, and pred_takeD=1 from ctr=10 onward.
- **Aliasing.**
  - With 0x00400020 allocated, lookup 0x00400420 (same index 8, different tag) gives hitD=0.
  - A not-taken update for 0x00400420 leaves 0x00400020 still hitting.
  - A taken update for 0x00400420 with targetM=0x00400500 evicts it: 0x00400020 then misses, and 0x00400420 hits with targetD=0x00400500, ctrD=10.
- **Same-cycle read/write.** Lookup 0x00400020 on the same edge as a taken allocate of 0x00400020 gives hitD=0. A repeat lookup one cycle later gives hitD=1.
- **Stall/flush.**
  - With a hit held, stallD=1 for 3 cycles while pcF changes to a missing PC: outputs stay at the hit values.
  - flushD=1 (with or without stallD) clears the outputs to 0 on the next edge.
- **Reset mid-operation.** With 4 entries allocated, pull rst low for one cycle while branchM=1 (taken) for a fifth PC. After rst returns high, lookups of all five PCs give hitD=0.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: fetch-stage lookup with a registered,
// decode-aligned result, trained by resolved branches from the memory stage.
module branch_target_buffer #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        branchM,
  input  logic [31:0] pcM,
  input  logic        actual_takeM,
  input  logic [31:0] targetM,
  output logic        hitD,
  output logic        pred_takeD,
  output logic [31:0] targetD,
  output logic [1:0]  ctrD
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];

  logic        hit_q, hit_d;
  logic [31:0] target_q, target_d;
  logic [1:0]  ctr_q, ctr_d;

  // Word-aligned PCs: the two low address bits never take part in indexing.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pcF[1:0], pcM[1:0]};

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;
  logic [1:0]       upd_ctr;

  assign lk_idx  = pcF[IDX_W+1:2];
  assign lk_tag  = pcF[31:IDX_W+2];
  assign upd_idx = pcM[IDX_W+1:2];
  assign upd_tag = pcM[31:IDX_W+2];

  // Both ports read the pre-edge table, which gives read-old behaviour when
  // a lookup and an update hit the same index on the same edge.
  assign lk_hit  = valid_q[lk_idx]  && (entry_q[lk_idx].tag  == lk_tag);
  assign upd_hit = valid_q[upd_idx] && (entry_q[upd_idx].tag == upd_tag);
  assign upd_ctr = entry_q[upd_idx].ctr;

  // Table training.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    valid_d = valid_q;
    entry_d = entry_q;
    if (branchM) begin
      if (upd_hit) begin
        if (actual_takeM) begin
          entry_d[upd_idx].ctr    = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'd1;
          entry_d[upd_idx].target = targetM;
        end else begin
          entry_d[upd_idx].ctr    = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'd1;
        end
      end else if (actual_takeM) begin
        valid_d[upd_idx] = 1'b1;
        entry_d[upd_idx] = '{tag: upd_tag, target: targetM, ctr: 2'b10};
      end
    end
  end

  // Decode-stage result register: flush beats stall beats load.
  always_comb begin
    hit_d    = hit_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (flushD) begin
      hit_d    = 1'b0;
      target_d = '0;
      ctr_d    = '0;
    end else if (!stallD) begin
      hit_d    = lk_hit;
      target_d = lk_hit ? entry_q[lk_idx].target : '0;
      ctr_d    = lk_hit ? entry_q[lk_idx].ctr    : '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      valid_q  <= '0;
      hit_q    <= 1'b0;
      target_q <= '0;
      ctr_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      hit_q    <= hit_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

  // NOTE: entry payload is left out of reset; it is meaningless while its valid bit is clear.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign hitD       = hit_q;
  assign targetD    = target_q;
  assign ctrD       = ctr_q;
  assign pred_takeD = hit_q & ctr_q[1];

endmodule
